// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide with HI/LO; in clk rst start aluOpcode a b, out busy done stall hi lo result
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       aluOpcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_next;
  logic op_div, neg_q, neg_r, dz;
  logic [WIDTH-1:0] mcand, mplier, quo, rem;
  logic [2*WIDTH-1:0] acc, prod, mul_next, div_next;
  logic [CW-1:0] cnt;
  logic is_md, is_hl, accept, sgn, sa, sb;
  logic [WIDTH:0] mul_sum, rem_sh, div_diff;
  assign is_md = aluOpcode[5:2] == 4'b0110;
  assign is_hl = aluOpcode[5:2] == 4'b0100;
  assign accept = start && is_md && state == IDLE;
  assign sgn = !aluOpcode[0];
  assign sa = sgn && a[WIDTH-1];
  assign sb = sgn && b[WIDTH-1];
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{mplier[0]}}};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign rem_sh = {acc[2*WIDTH-1:WIDTH], mcand[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, mplier};
  assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign prod = neg_q ? -acc : acc;
  assign quo = dz ? '1 : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_comb
    state_next = state == IDLE ? (accept ? RUN : IDLE)
               : state == RUN ? (cnt == CW'(WIDTH-1) ? FIX : RUN) : IDLE;
  always_comb begin
    busy = state != IDLE;
    stall = start && (is_md || is_hl) && busy;
    result = aluOpcode == 6'h10 ? hi : aluOpcode == 6'h12 ? lo : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {op_div, neg_q, neg_r, dz} <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FIX;
      if (accept) begin
        op_div <= aluOpcode[1];
        neg_q <= sa ^ sb;
        neg_r <= sa;
        dz <= b == '0;
        mcand <= sa ? -a : a;
        mplier <= sb ? -b : b;
        acc <= '0;
        cnt <= '0;
      end
      if (state == RUN) begin
        acc <= op_div ? div_next : mul_next;
        mcand <= op_div ? mcand << 1 : mcand;
        mplier <= op_div ? mplier : mplier >> 1;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        hi <= op_div ? rem : prod[2*WIDTH-1:WIDTH];
        lo <= op_div ? quo : prod[WIDTH-1:0];
      end
      if (start && state == IDLE && aluOpcode == 6'h11) hi <= a;
      if (start && state == IDLE && aluOpcode == 6'h13) lo <= a;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  localparam int W = 32;
  logic clk = 0, rst = 1, start = 0;
  logic [5:0] op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic busy, done, stall;
  logic [W-1:0] hi, lo, result;
  int vecs = 0, errs = 0;
  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .aluOpcode(op), .a(a), .b(b),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo), .result(result)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (o == 6'h18) return sx * sy;
    if (o == 6'h19) return ux * uy;
    if (y == 0) return {x, 32'hFFFFFFFF};
    if (o == 6'h1A) begin
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction
  task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    op = 0;
    a = $urandom;
    b = $urandom;
  endtask
  task automatic wait_done(output int n, output bit both);
    n = -1;
    both = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (busy && done) both = 1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic test_reset;
    rst = 1;
    start = 1;
    op = 6'h10;
    repeat (2) @(posedge clk);
    #1;
    vecs += 6;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done); end
    if (hi !== 0) begin errs++; $display("FAIL reset_hi got %h want 0", hi); end
    if (lo !== 0) begin errs++; $display("FAIL reset_lo got %h want 0", lo); end
    if (result !== 0) begin errs++; $display("FAIL reset_result got %h want 0", result); end
    if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b want 0", stall); end
    rst = 0;
    start = 0;
    op = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_mult;
    logic [5:0] o;
    logic [31:0] x, y;
    logic [63:0] e;
    int n;
    bit both;
    for (int i = 0; i < 10; i++) begin
      o = ($urandom & 1) ? 6'h18 : 6'h19;
      x = $urandom;
      y = $urandom;
      if (i == 0) begin o = 6'h19; x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; end
      if (i == 1) begin o = 6'h18; x = 32'hFFFFFFFD; y = 7; end
      if (i == 2) begin o = 6'h18; x = 32'h80000000; y = 32'h80000000; end
      if (i == 3) begin o = 6'h18; x = 32'h7FFFFFFF; y = 32'hFFFFFFFF; end
      e = model(o, x, y);
      issue(o, x, y);
      wait_done(n, both);
      vecs += 3;
      if (n !== 33) begin errs++; $display("FAIL mult_latency op=%h got %0d want 33", o, n); end
      if (both !== 1'b0) begin errs++; $display("FAIL mult_busy_done_overlap got %b want 0", both); end
      if ({hi, lo} !== e) begin errs++; $display("FAIL mult_result op=%h a=%h b=%h got %h want %h", o, x, y, {hi, lo}, e); end
    end
  endtask
  task automatic test_div;
    logic [5:0] o;
    logic [31:0] x, y;
    logic [63:0] e;
    int n;
    bit both;
    for (int i = 0; i < 14; i++) begin
      o = ($urandom & 1) ? 6'h1A : 6'h1B;
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) y = -y;
      if (i == 0) begin o = 6'h1A; x = 32'hFFFFFFF9; y = 2; end
      if (i == 1) begin o = 6'h1B; x = 100; y = 0; end
      if (i == 2) begin o = 6'h1A; x = 32'h80000000; y = 32'hFFFFFFFF; end
      if (i == 3) begin o = 6'h1A; x = 32'hFFFFFFF0; y = 0; end
      if (i == 4) begin o = 6'h1A; x = 7; y = 32'hFFFFFFFE; end
      if (i == 5) begin o = 6'h1B; x = 32'hFFFFFFFF; y = 1; end
      e = model(o, x, y);
      issue(o, x, y);
      wait_done(n, both);
      vecs += 3;
      if (n !== 33) begin errs++; $display("FAIL div_latency op=%h got %0d want 33", o, n); end
      if (both !== 1'b0) begin errs++; $display("FAIL div_busy_done_overlap got %b want 0", both); end
      if ({hi, lo} !== e) begin errs++; $display("FAIL div_result op=%h a=%h b=%h got %h want %h", o, x, y, {hi, lo}, e); end
    end
  endtask
  task automatic test_stall;
    logic [31:0] x, y, lo_before;
    logic [63:0] e;
    int n;
    bit both;
    x = $urandom;
    y = $urandom;
    e = model(6'h18, x, y);
    lo_before = lo;
    issue(6'h18, x, y);
    repeat (9) @(posedge clk);
    #1;
    start = 1;
    op = 6'h12;
    #1;
    vecs++;
    if (stall !== 1'b1) begin errs++; $display("FAIL stall_mflo got %b want 1", stall); end
    op = 6'h20;
    #1;
    vecs++;
    if (stall !== 1'b0) begin errs++; $display("FAIL stall_unknown got %b want 0", stall); end
    op = 6'h13;
    a = $urandom;
    #1;
    vecs++;
    if (stall !== 1'b1) begin errs++; $display("FAIL stall_mtlo got %b want 1", stall); end
    @(posedge clk);
    #1;
    start = 0;
    op = 0;
    vecs++;
    if (lo !== lo_before) begin errs++; $display("FAIL stall_lo_held got %h want %h", lo, lo_before); end
    wait_done(n, both);
    vecs += 2;
    if (n !== 23) begin errs++; $display("FAIL stall_latency got %0d want 23", n); end
    if ({hi, lo} !== e) begin errs++; $display("FAIL stall_result got %h want %h", {hi, lo}, e); end
    start = 1;
    op = 6'h12;
    #1;
    vecs += 2;
    if (result !== e[31:0]) begin errs++; $display("FAIL mflo_result got %h want %h", result, e[31:0]); end
    if (stall !== 1'b0) begin errs++; $display("FAIL mflo_idle_stall got %b want 0", stall); end
    op = 6'h10;
    #1;
    vecs++;
    if (result !== e[63:32]) begin errs++; $display("FAIL mfhi_result got %h want %h", result, e[63:32]); end
    op = 6'h20;
    #1;
    vecs++;
    if (result !== 0) begin errs++; $display("FAIL other_result got %h want 0", result); end
    start = 0;
    op = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset_abort;
    bit seen;
    issue(6'h11, 32'h12345678, 0);
    vecs += 3;
    if (hi !== 32'h12345678) begin errs++; $display("FAIL mthi got %h want 12345678", hi); end
    if (busy !== 1'b0) begin errs++; $display("FAIL mthi_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errs++; $display("FAIL mthi_done got %b want 0", done); end
    issue(6'h1B, $urandom, 32'd3 + ($urandom & 32'hFFFF));
    repeat (14) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    vecs += 4;
    if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy got %b want 0", busy); end
    if (hi !== 0) begin errs++; $display("FAIL abort_hi got %h want 0", hi); end
    if (lo !== 0) begin errs++; $display("FAIL abort_lo got %h want 0", lo); end
    if (done !== 1'b0) begin errs++; $display("FAIL abort_done got %b want 0", done); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1;
    end
    vecs++;
    if (seen !== 1'b0) begin errs++; $display("FAIL abort_quiet got %b want 0", seen); end
    issue(6'h13, 5, 0);
    vecs += 2;
    if (lo !== 5) begin errs++; $display("FAIL mtlo got %h want 5", lo); end
    if (hi !== 0) begin errs++; $display("FAIL mtlo_hi got %h want 0", hi); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] x1, y1, x2, y2;
    logic [63:0] e1, e2;
    int n;
    bit both;
    x1 = $urandom;
    y1 = $urandom >> 8;
    x2 = $urandom;
    y2 = $urandom;
    e1 = model(6'h1B, x1, y1);
    e2 = model(6'h18, x2, y2);
    issue(6'h1B, x1, y1);
    wait_done(n, both);
    vecs += 2;
    if (n !== 33) begin errs++; $display("FAIL b2b_first_latency got %0d want 33", n); end
    if ({hi, lo} !== e1) begin errs++; $display("FAIL b2b_first_result got %h want %h", {hi, lo}, e1); end
    issue(6'h18, x2, y2);
    vecs++;
    if (busy !== 1'b1) begin errs++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
    wait_done(n, both);
    vecs += 3;
    if (n !== 33) begin errs++; $display("FAIL b2b_second_latency got %0d want 33", n); end
    if (both !== 1'b0) begin errs++; $display("FAIL b2b_overlap got %b want 0", both); end
    if ({hi, lo} !== e2) begin errs++; $display("FAIL b2b_second_result got %h want %h", {hi, lo}, e2); end
  endtask
  initial begin
    test_reset;
    test_mult;
    test_div;
    test_stall;
    test_reset_abort;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
